// File: rtl/tag_controller_pkg.sv
// Shared types for the direct-mapped cache tag controller: tag entry layout and FSM states.
package tag_controller_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned TAG_SIZE_DEF   = 20;

    typedef struct packed {
        logic                    valid;
        logic [TAG_SIZE_DEF-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        RESET_FLUSH,
        IDLE,
        FLUSH
    } tag_ctrl_state_t;

endpackage

// File: rtl/tag_controller.sv
// Tag memory sequencer: flush sweep / allocate / lookup arbitration on port 0, snoop on port 1.
// Optional hit/miss counters are enabled with the TAG_CONTROLLER_STATS_EN macro.
module tag_controller
    import tag_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned TAG_SIZE   = TAG_SIZE_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      lookup_valid_i,
    input  logic [ADDR_WIDTH-1:0]     lookup_index_i,
    input  logic [TAG_SIZE-1:0]       lookup_tag_i,
    output logic                      lookup_ready_o,
    output logic                      result_valid_o,
    output logic                      hit_o,
    input  logic                      allocate_valid_i,
    input  logic [ADDR_WIDTH-1:0]     allocate_index_i,
    input  logic [TAG_SIZE-1:0]       allocate_tag_i,
    output logic                      allocate_ready_o,
    input  logic                      invalidate_i,
    output logic                      flush_busy_o,
    input  logic                      snoop_valid_i,
    input  logic [ADDR_WIDTH-1:0]     snoop_index_i,
    input  logic [TAG_SIZE-1:0]       snoop_tag_i,
    output logic                      snoop_result_valid_o,
    output logic                      snoop_hit_o,
`ifdef TAG_CONTROLLER_STATS_EN
    output logic [31:0]               hit_count_o,
    output logic [31:0]               miss_count_o,
`endif
    output logic [ADDR_WIDTH-1:0]     mem_rw_address_o,
    output logic [TAG_SIZE:0]         mem_write_tag_o,
    output logic                      mem_write_o,
    output logic [1:0]                mem_read_o,
    output logic [ADDR_WIDTH-1:0]     mem_read_address_o,
    input  logic [2*(TAG_SIZE+1)-1:0] mem_read_tag_i
);

    localparam int unsigned EW = TAG_SIZE + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef struct packed {
        logic                valid;
        logic [TAG_SIZE-1:0] tag;
    } entry_t;

    tag_ctrl_state_t       r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                  w_do_lookup;
    entry_t                w_wdata, w_rd0, w_rd1, w_snoop_entry;
    logic                  r_lookup_pend, r_snoop_pend, r_fwd;
    logic [TAG_SIZE-1:0]   r_lookup_tag, r_snoop_tag;
    entry_t                r_fwd_data;

    assign w_rd0 = mem_read_tag_i[EW-1:0];
    assign w_rd1 = mem_read_tag_i[2*EW-1:EW];

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        lookup_ready_o   = 1'b0;
        allocate_ready_o = 1'b0;
        mem_write_o      = 1'b0;
        mem_rw_address_o = lookup_index_i;
        w_wdata          = '0;
        w_do_lookup      = 1'b0;
        unique case (r_state)
            RESET_FLUSH, FLUSH: begin
                mem_write_o      = 1'b1;
                mem_rw_address_o = r_cnt;
                w_cnt_next       = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (invalidate_i) begin
                    w_state_next = FLUSH;
                    w_cnt_next   = '0;
                end else if (allocate_valid_i) begin
                    allocate_ready_o = 1'b1;
                    mem_write_o      = 1'b1;
                    mem_rw_address_o = allocate_index_i;
                    w_wdata          = '{valid: 1'b1, tag: allocate_tag_i};
                end else begin
                    allocate_ready_o = 1'b1;
                    lookup_ready_o   = 1'b1;
                    w_do_lookup      = lookup_valid_i;
                end
            end
            default: w_state_next = RESET_FLUSH;
        endcase
    end

    assign flush_busy_o       = (r_state != IDLE);
    assign mem_write_tag_o    = w_wdata;
    assign mem_read_o         = {snoop_valid_i, w_do_lookup};
    assign mem_read_address_o = snoop_index_i;

    // The memory reads old data on a same-cycle write, so a colliding write is forwarded to the snoop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= RESET_FLUSH;
            r_cnt         <= '0;
            r_lookup_pend <= 1'b0;
            r_lookup_tag  <= '0;
            r_snoop_pend  <= 1'b0;
            r_snoop_tag   <= '0;
            r_fwd         <= 1'b0;
            r_fwd_data    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_lookup_pend <= w_do_lookup;
            if (w_do_lookup) begin
                r_lookup_tag <= lookup_tag_i;
            end
            r_snoop_pend  <= snoop_valid_i;
            r_snoop_tag   <= snoop_tag_i;
            r_fwd         <= mem_write_o && (mem_rw_address_o == snoop_index_i);
            r_fwd_data    <= w_wdata;
        end
    end

    assign w_snoop_entry        = r_fwd ? r_fwd_data : w_rd1;
    assign result_valid_o       = r_lookup_pend;
    assign hit_o                = r_lookup_pend && w_rd0.valid && (w_rd0.tag == r_lookup_tag);
    assign snoop_result_valid_o = r_snoop_pend;
    assign snoop_hit_o          = r_snoop_pend && w_snoop_entry.valid && (w_snoop_entry.tag == r_snoop_tag);

`ifdef TAG_CONTROLLER_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_lookup_pend) begin
            if (hit_o) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`endif

endmodule
